// File: rtl/stb_pkg.sv
// Shared types and sizing helpers for the dsram store buffer.
// The entry struct is sized for 64-bit addresses and 64-bit data words.
package stb_pkg;
  localparam int STB_AW = 64;
  localparam int STB_DW = 64;
  localparam int OFFS_W = 3;
  localparam int MASK_W = STB_DW / 8;
  localparam int TAG_W  = STB_AW - OFFS_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [STB_DW-1:0] data;
    logic [MASK_W-1:0] mask;
  } sb_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/stb_fwd_merge.sv
// Combinational load/store-buffer match: per-byte merge of the youngest matching
// entry over memory data, plus a flag for any valid entry on the load's word.
module stb_fwd_merge
  import stb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [TAG_W-1:0]      ld_tag,
  input  logic [STB_DW-1:0]     mem_rdata,
  output logic [STB_DW-1:0]     merged,
  output logic                  hit
);
  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (entries[i].tag == ld_tag);
  end

  assign hit = |match;

  // Walk oldest to youngest from head so the last matching byte wins.
  for (genvar l = 0; l < MASK_W; l++) begin : g_lane
    logic [7:0]       lane_d;
    logic [PTR_W-1:0] idx;
    always_comb begin
      lane_d = mem_rdata[l*8 +: 8];
      idx    = head;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if (match[idx] && entries[idx].mask[l])
          lane_d = entries[idx].data[l*8 +: 8];
      end
    end
    assign merged[l*8 +: 8] = lane_d;
  end
endmodule

// File: rtl/dsram_store_buffer.sv
// Write-buffered bridge between the core dsram port and the memory model.
// Optional STB_LOAD_FWD_EN: conflicting loads forward from the buffer instead of stalling.
module dsram_store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = STB_AW,
  parameter int DW    = STB_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dsram_e,
  input  logic            dsram_we,
  input  logic [AW-1:0]   dsram_addr,
  input  logic [DW-1:0]   dsram_wdata,
  input  logic [DW/8-1:0] dsram_sel,
  output logic [DW-1:0]   dsram_rdata,
  output logic            dsram_stall,
  output logic [AW-1:0]   mem_raddr,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  output logic            sb_empty
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head, tail, wr_idx;
  logic [CNT_W-1:0]      count;
  logic [TAG_W-1:0]      ld_tag;
  logic [DW-1:0]         fwd_data;
  logic                  is_st, is_ld, full, drain, enq, ld_hit;
  logic                  unused_addr_lsb;

  assign ld_tag    = dsram_addr[AW-1:OFFS_W];
  assign is_st     = dsram_e & dsram_we;
  assign is_ld     = dsram_e & ~dsram_we;
  assign full      = (count == CNT_W'(DEPTH));
  assign drain     = (count != '0);
  assign sb_empty  = ~drain;
  assign mem_raddr = {dsram_addr[AW-1:OFFS_W], {OFFS_W{1'b0}}};
  assign unused_addr_lsb = ^dsram_addr[OFFS_W-1:0];

  stb_fwd_merge #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .entries   (entries),
    .valid     (valid),
    .head      (head),
    .ld_tag    (ld_tag),
    .mem_rdata (mem_rdata),
    .merged    (fwd_data),
    .hit       (ld_hit)
  );

`ifdef STB_LOAD_FWD_EN
  assign dsram_stall = is_st & full;
  assign dsram_rdata = fwd_data;
`else
  logic unused_fwd;
  assign unused_fwd  = ^fwd_data;
  assign dsram_stall = (is_st & full) | (is_ld & ld_hit);
  assign dsram_rdata = mem_rdata;
`endif

  // Full stalls even when the head drains this cycle; empty masks are dropped.
  assign enq = is_st & ~dsram_stall & (|dsram_sel);

  // When empty, show the most recently drained entry so mem_w* hold still.
  assign wr_idx    = drain ? head : head - 1'b1;
  assign mem_we    = drain;
  assign mem_waddr = {entries[wr_idx].tag, {OFFS_W{1'b0}}};
  assign mem_wdata = entries[wr_idx].data;
  assign mem_wmask = entries[wr_idx].mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid   <= '0;
      entries <= '0;
    end else begin
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (enq) begin
        valid[tail]        <= 1'b1;
        entries[tail].tag  <= ld_tag;
        entries[tail].data <= dsram_wdata;
        entries[tail].mask <= dsram_sel;
        tail               <= tail + 1'b1;
      end
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end
endmodule

// File: tb/tb_dsram_store_buffer.sv
// Scoreboard bench for dsram_store_buffer: a program-order store queue plus a word
// memory model predict stalls, load data and the memory write stream.
module tb_dsram_store_buffer;
  localparam int DEPTH = 4;
`ifdef STB_LOAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dsram_e = 1'b0, dsram_we = 1'b0;
  logic [63:0] dsram_addr = '0, dsram_wdata = '0;
  logic [7:0]  dsram_sel = '0;
  logic [63:0] dsram_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        dsram_stall, mem_we, sb_empty;
  logic [7:0]  mem_wmask;

  dsram_store_buffer #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst), .dsram_e(dsram_e), .dsram_we(dsram_we),
    .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata), .dsram_sel(dsram_sel),
    .dsram_rdata(dsram_rdata), .dsram_stall(dsram_stall), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [60:0] tag; logic [63:0] data; logic [7:0] mask; } st_t;
  typedef struct { bit e; bit we; bit stall; logic [63:0] rdata; } core_t;

  st_t   pend[$];     // stores the model holds in the buffer, oldest first
  st_t   exp_wq[$];   // writes still expected on the memory port
  core_t exp_cq[$];   // one core-side expectation per driven cycle
  logic [63:0] env_mem [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  int env_gen = 0;
  int n_vec = 0, n_fail = 0;

  function automatic logic [63:0] dflt(input logic [60:0] t);
    return {~t[31:0], t[31:0]};
  endfunction
  function automatic logic [63:0] env_rd(input logic [60:0] t);
    return env_mem.exists(t) ? env_mem[t] : dflt(t);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [60:0] t);
    return ref_mem.exists(t) ? ref_mem[t] : dflt(t);
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model the DUT reads and writes (same-cycle read, write at the edge).
  always @(mem_raddr or env_gen) mem_rdata = env_rd(mem_raddr[63:3]);
  initial forever begin
    @(posedge clk);
    if (rst && mem_we) begin
      env_mem[mem_waddr[63:3]] = merge(env_rd(mem_waddr[63:3]), mem_wdata, mem_wmask);
      env_gen++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a core result or a write.
  initial begin : mon
    core_t c;
    st_t   w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_cq.size() > 0) begin
          c = exp_cq.pop_front();
          check("dsram_stall", 64'(dsram_stall), 64'(c.stall));
          if (c.e && !c.we && !c.stall) check("dsram_rdata", dsram_rdata, c.rdata);
        end
        check("sb_empty", 64'(sb_empty), 64'(pend.size() == 0));
        check("mem_we", 64'(mem_we), 64'(pend.size() != 0));
        if (mem_we) begin
          if (exp_wq.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL mem_write: got write to %h, expected no write", mem_waddr);
          end else begin
            w = exp_wq.pop_front();
            check("mem_waddr", mem_waddr, {w.tag, 3'b000});
            check("mem_wdata", mem_wdata, w.data);
            check("mem_wmask", 64'(mem_wmask), 64'(w.mask));
          end
        end
      end
    end
  end

  // One core cycle: predict, push the expectation, advance the model at the edge.
  task automatic cycle(input bit e, input bit we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] sel,
                       input bit use_k, input logic [63:0] kval, output bit stalled);
    core_t c;
    st_t s;
    logic [60:0] t;
    logic [63:0] rd;
    bit conflict;
    dsram_e = e; dsram_we = we; dsram_addr = addr; dsram_wdata = wd; dsram_sel = sel;
    t = addr[63:3];
    conflict = 1'b0;
    rd = ref_rd(t);
    foreach (pend[i]) if (pend[i].tag == t) begin
      conflict = 1'b1;
      rd = merge(rd, pend[i].data, pend[i].mask);
    end
    c.e = e; c.we = we;
    c.stall = e && (we ? (pend.size() == DEPTH) : (!FWD && conflict));
    c.rdata = use_k ? kval : rd;
    exp_cq.push_back(c);
    @(posedge clk);
    if (pend.size() > 0) begin
      s = pend.pop_front();
      ref_mem[s.tag] = merge(ref_rd(s.tag), s.data, s.mask);
    end
    if (e && we && !c.stall && sel != 8'h00) begin
      s.tag = t; s.data = wd; s.mask = sel;
      pend.push_back(s);
      exp_wq.push_back(s);
    end
    #1;
    stalled = c.stall;
  endtask

  // The core holds a stalled request and retries it, within a cycle budget.
  task automatic access(input bit e, input bit we, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] sel,
                        input bit use_k, input logic [63:0] kval);
    bit st;
    int tries;
    tries = 0;
    do begin
      cycle(e, we, addr, wd, sel, use_k, kval, st);
      tries++;
    end while (st && tries < 16);
    if (st) begin
      n_vec++; n_fail++;
      $display("FAIL retry_bound: still stalled after %0d cycles, expected release", tries);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, d;
    logic [7:0]  m;
    int op;
    env_mem[61'h10000002] = 64'hCCCCCCCC_DDDDDDDD;
    ref_mem[61'h10000002] = 64'hCCCCCCCC_DDDDDDDD;
    env_mem[61'h10000004] = 64'h0;
    ref_mem[61'h10000004] = 64'h0;

    #1;
    check("reset_mem_we", 64'(mem_we), 64'h0);
    check("reset_sb_empty", 64'(sb_empty), 64'h1);
    check("reset_stall", 64'(dsram_stall), 64'h0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Single full-mask store, then drain.
    access(1'b1, 1'b1, 64'h80000008, 64'h11223344_55667788, 8'hFF, 1'b0, 64'h0);
    idle(2);

    // Partial store then load of the upper half of the same word.
    access(1'b1, 1'b1, 64'h80000010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b0, 64'h0);
    access(1'b1, 1'b0, 64'h80000014, 64'h0, 8'h00, 1'b1, 64'hCCCCCCCC_BBBBBBBB);
    idle(1);

    // Two byte-0 stores to one word; the younger value must be seen.
    access(1'b1, 1'b1, 64'h80000020, 64'h01, 8'h01, 1'b0, 64'h0);
    access(1'b1, 1'b1, 64'h80000020, 64'h02, 8'h01, 1'b0, 64'h0);
    access(1'b1, 1'b0, 64'h80000020, 64'h0, 8'h00, 1'b1, 64'h2);
    idle(2);

    // Back-to-back stores: program order and pointer wrap.
    for (int k = 0; k < 12; k++)
      access(1'b1, 1'b1, 64'h80000040 + 64'(k * 8), {$urandom, $urandom}, 8'($urandom_range(1, 255)),
             1'b0, 64'h0);
    access(1'b1, 1'b1, 64'h80000048, 64'h5A, 8'h00, 1'b0, 64'h0);
    idle(2);

    // Reset while a store is still buffered: it must be dropped.
    access(1'b1, 1'b1, 64'h80000030, 64'hDEADBEEF_0BADF00D, 8'hFF, 1'b0, 64'h0);
    #1 rst = 1'b0;
    dsram_e = 1'b0;
    #1;
    check("midreset_mem_we", 64'(mem_we), 64'h0);
    check("midreset_sb_empty", 64'(sb_empty), 64'h1);
    pend.delete(); exp_wq.delete(); exp_cq.delete();
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    idle(3);
    access(1'b1, 1'b0, 64'h80000030, 64'h0, 8'h00, 1'b0, 64'h0);

    // Random traffic over a few words so loads and stores collide often.
    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 99);
      a  = 64'h80000000 + 64'($urandom_range(0, 63));
      d  = {$urandom, $urandom};
      m  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if (op < 45)      access(1'b1, 1'b1, a, d, m, 1'b0, 64'h0);
      else if (op < 80) access(1'b1, 1'b0, a, d, m, 1'b0, 64'h0);
      else              access(1'b0, op[0], a, d, m, 1'b0, 64'h0);
    end
    idle(4);
    if (exp_wq.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain_done: got %0d writes outstanding, expected 0", exp_wq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
